// File: rtl/addr_accum.sv
`default_nettype none
// ============================================================================
// Module      : addr_accum
// Description : NCH-lane WIDTH-bit adder with a windowed accumulate mode
//               (optional saturation, sticky overflow) behind a valid/ready
//               handshake with a single output register.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_accum #(
    parameter int WIDTH     = 4,
    parameter int NCH       = 2,
    parameter int ACC_WIDTH = 8,
    parameter int WINDOW    = 4,
    parameter int SAT       = 1
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic [NCH*WIDTH-1:0]     a_i,
    input  logic [NCH*WIDTH-1:0]     b_i,
    input  logic [1:0]               mode_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [NCH*ACC_WIDTH-1:0] c_o,
    output logic [NCH-1:0]           ovf_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    localparam int             CNT_W       = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WINDOW - 1);

    localparam logic [1:0] C_MODE_ADD = 2'b00;
    localparam logic [1:0] C_MODE_ACC = 2'b01;
    localparam logic [1:0] C_MODE_CLR = 2'b10;

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_fire;
    logic w_add;
    logic w_acc;
    logic w_clr;
    logic w_dump;
    logic w_load;

    assign valid_o = (r_state == S_FULL);
    assign ready_o = !valid_o || ready_i;

    // Mode 11 fires the handshake but matches none of the decodes below.
    assign w_fire = valid_i && ready_o;
    assign w_add  = w_fire && (mode_i == C_MODE_ADD);
    assign w_acc  = w_fire && (mode_i == C_MODE_ACC);
    assign w_clr  = w_fire && (mode_i == C_MODE_CLR);
    assign w_dump = w_acc && (r_cnt == C_CNT_LAST);
    assign w_load = w_add || w_dump;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_load) r_state <= S_FULL;
                S_FULL:  if (ready_i && !w_load) r_state <= S_EMPTY;
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt <= '0;
        end else if (w_clr || w_dump) begin
            r_cnt <= '0;
        end else if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_lane
            logic [WIDTH-1:0]     w_a;
            logic [WIDTH-1:0]     w_b;
            logic [ACC_WIDTH:0]   w_sum;
            logic                 w_ovf;
            logic [ACC_WIDTH-1:0] w_acc_nxt;
            logic [ACC_WIDTH-1:0] w_add_res;
            logic [ACC_WIDTH-1:0] r_acc;
            logic                 r_sticky;
            logic [ACC_WIDTH-1:0] r_c;
            logic                 r_ovf;

            assign w_a = a_i[k*WIDTH +: WIDTH];
            assign w_b = b_i[k*WIDTH +: WIDTH];

            // One extra bit is enough: ACC_WIDTH >= WIDTH+1 bounds acc+a+b.
            assign w_sum = {1'b0, r_acc}
                         + {{(ACC_WIDTH+1-WIDTH){1'b0}}, w_a}
                         + {{(ACC_WIDTH+1-WIDTH){1'b0}}, w_b};
            assign w_ovf     = w_sum[ACC_WIDTH];
            assign w_acc_nxt = (w_ovf && (SAT != 0)) ? {ACC_WIDTH{1'b1}}
                                                     : w_sum[ACC_WIDTH-1:0];
            assign w_add_res = {{(ACC_WIDTH-WIDTH){1'b0}}, w_a}
                             + {{(ACC_WIDTH-WIDTH){1'b0}}, w_b};

            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    r_acc    <= '0;
                    r_sticky <= 1'b0;
                end else if (w_clr || w_dump) begin
                    r_acc    <= '0;
                    r_sticky <= 1'b0;
                end else if (w_acc) begin
                    r_acc    <= w_acc_nxt;
                    r_sticky <= r_sticky | w_ovf;
                end
            end

            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    r_c   <= '0;
                    r_ovf <= 1'b0;
                end else if (w_add) begin
                    r_c   <= w_add_res;
                    r_ovf <= 1'b0;
                end else if (w_dump) begin
                    r_c   <= w_acc_nxt;
                    r_ovf <= r_sticky | w_ovf;
                end
            end

            assign c_o[k*ACC_WIDTH +: ACC_WIDTH] = r_c;
            assign ovf_o[k]                      = r_ovf;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_addr_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_accum
// Description : Directed self-checking bench for addr_accum (default build
//               plus WINDOW=16 builds with and without saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_accum;

    localparam logic [1:0] C_ADD = 2'b00;
    localparam logic [1:0] C_ACC = 2'b01;
    localparam logic [1:0] C_CLR = 2'b10;
    localparam logic [1:0] C_RSV = 2'b11;

    logic        clk = 1'b0;
    logic        rstb;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic [1:0]  mode_i;
    logic        valid_i;
    logic        ready_i;

    logic        d_ro, d_vo;
    logic [15:0] d_c;
    logic [1:0]  d_ovf;
    logic        s1_ro, s1_vo;
    logic [15:0] s1_c;
    logic [1:0]  s1_ovf;
    logic        s0_ro, s0_vo;
    logic [15:0] s0_c;
    logic [1:0]  s0_ovf;

    logic [7:0] d_l0, d_l1, s1_l0, s0_l0;
    assign d_l0  = d_c[7:0];
    assign d_l1  = d_c[15:8];
    assign s1_l0 = s1_c[7:0];
    assign s0_l0 = s0_c[7:0];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    addr_accum u_dut (
        .clk(clk), .rstb(rstb), .a_i(a_i), .b_i(b_i), .mode_i(mode_i),
        .valid_i(valid_i), .ready_o(d_ro), .c_o(d_c), .ovf_o(d_ovf),
        .valid_o(d_vo), .ready_i(ready_i)
    );

    addr_accum #(.WINDOW(16), .SAT(1)) u_sat1 (
        .clk(clk), .rstb(rstb), .a_i(a_i), .b_i(b_i), .mode_i(mode_i),
        .valid_i(valid_i), .ready_o(s1_ro), .c_o(s1_c), .ovf_o(s1_ovf),
        .valid_o(s1_vo), .ready_i(ready_i)
    );

    addr_accum #(.WINDOW(16), .SAT(0)) u_sat0 (
        .clk(clk), .rstb(rstb), .a_i(a_i), .b_i(b_i), .mode_i(mode_i),
        .valid_i(valid_i), .ready_o(s0_ro), .c_o(s0_c), .ovf_o(s0_ovf),
        .valid_o(s0_vo), .ready_i(ready_i)
    );

    // One accepted beat (callers keep ready_o high), sampled 1 ns after the edge.
    task automatic beat(input logic [1:0] m, input logic [3:0] a0, input logic [3:0] b0,
                        input logic [3:0] a1, input logic [3:0] b1);
        mode_i  = m;
        a_i     = {a1, a0};
        b_i     = {b1, b0};
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic idle();
        valid_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rstb = 1'b0;
        #2 rstb = 1'b1;
    endtask

    task automatic test_reset();
        rstb = 1'b1; ready_i = 1'b1; valid_i = 1'b0; mode_i = C_ADD; a_i = '0; b_i = '0;
        #1 rstb = 1'b0;
        #1;
        total++; if (d_vo !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", d_vo); end
        total++; if (d_c !== 16'h0) begin bad++; $display("FAIL reset_c got=%h exp=0000", d_c); end
        total++; if (d_ovf !== 2'b00) begin bad++; $display("FAIL reset_ovf got=%b exp=00", d_ovf); end
        total++; if (d_ro !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", d_ro); end
        #4 rstb = 1'b1;
    endtask

    task automatic test_add();
        beat(C_ADD, 4'd15, 4'd15, 4'd3, 4'd4);
        total++; if (d_l0 !== 8'd30) begin bad++; $display("FAIL add_lane0 got=%0d exp=30", d_l0); end
        total++; if (d_l1 !== 8'd7) begin bad++; $display("FAIL add_lane1 got=%0d exp=7", d_l1); end
        total++; if (d_vo !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", d_vo); end
        total++; if (d_ovf !== 2'b00) begin bad++; $display("FAIL add_ovf got=%b exp=00", d_ovf); end
        idle();
        total++; if (d_vo !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", d_vo); end
    endtask

    task automatic test_acc_window();
        for (int i = 0; i < 3; i++) begin
            beat(C_ACC, 4'd5, 4'd5, 4'd1, 4'd0);
            total++; if (d_vo !== 1'b0) begin bad++; $display("FAIL acc_no_out beat=%0d got=%b exp=0", i + 1, d_vo); end
        end
        beat(C_ACC, 4'd5, 4'd5, 4'd1, 4'd0);
        total++; if (d_vo !== 1'b1) begin bad++; $display("FAIL acc_dump_valid got=%b exp=1", d_vo); end
        total++; if (d_l0 !== 8'd40) begin bad++; $display("FAIL acc_lane0 got=%0d exp=40", d_l0); end
        total++; if (d_l1 !== 8'd4) begin bad++; $display("FAIL acc_lane1 got=%0d exp=4", d_l1); end
        total++; if (d_ovf !== 2'b00) begin bad++; $display("FAIL acc_ovf got=%b exp=00", d_ovf); end
        for (int i = 0; i < 4; i++) beat(C_ACC, 4'd1, 4'd1, 4'd1, 4'd1);
        total++; if (d_vo !== 1'b1) begin bad++; $display("FAIL acc2_valid got=%b exp=1", d_vo); end
        total++; if (d_l0 !== 8'd8) begin bad++; $display("FAIL acc2_lane0 got=%0d exp=8", d_l0); end
        total++; if (d_l1 !== 8'd8) begin bad++; $display("FAIL acc2_lane1 got=%0d exp=8", d_l1); end
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int i = 0; i < 15; i++) beat(C_ACC, 4'd15, 4'd15, 4'd0, 4'd0);
        total++; if (s1_vo !== 1'b0) begin bad++; $display("FAIL sat_early_valid got=%b exp=0", s1_vo); end
        beat(C_ACC, 4'd15, 4'd15, 4'd0, 4'd0);
        total++; if (s1_vo !== 1'b1) begin bad++; $display("FAIL sat1_valid got=%b exp=1", s1_vo); end
        total++; if (s1_l0 !== 8'd255) begin bad++; $display("FAIL sat1_lane0 got=%0d exp=255", s1_l0); end
        total++; if (s1_ovf !== 2'b01) begin bad++; $display("FAIL sat1_ovf got=%b exp=01", s1_ovf); end
        total++; if (s0_l0 !== 8'd224) begin bad++; $display("FAIL sat0_lane0 got=%0d exp=224", s0_l0); end
        total++; if (s0_ovf !== 2'b01) begin bad++; $display("FAIL sat0_ovf got=%b exp=01", s0_ovf); end
        for (int i = 0; i < 16; i++) beat(C_ACC, 4'd1, 4'd0, 4'd0, 4'd0);
        total++; if (s1_l0 !== 8'd16) begin bad++; $display("FAIL sat1_next_lane0 got=%0d exp=16", s1_l0); end
        total++; if (s1_ovf !== 2'b00) begin bad++; $display("FAIL sat1_next_ovf got=%b exp=00", s1_ovf); end
        total++; if (s0_l0 !== 8'd16) begin bad++; $display("FAIL sat0_next_lane0 got=%0d exp=16", s0_l0); end
        total++; if (s0_ovf !== 2'b00) begin bad++; $display("FAIL sat0_next_ovf got=%b exp=00", s0_ovf); end
    endtask

    task automatic test_backpressure();
        idle();
        ready_i = 1'b0;
        beat(C_ADD, 4'd1, 4'd1, 4'd0, 4'd0);
        total++; if (d_vo !== 1'b1) begin bad++; $display("FAIL bp_first_valid got=%b exp=1", d_vo); end
        total++; if (d_l0 !== 8'd2) begin bad++; $display("FAIL bp_first_lane0 got=%0d exp=2", d_l0); end
        mode_i = C_ADD; a_i = 8'h02; b_i = 8'h02; valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++; if (d_ro !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, d_ro); end
            total++; if (d_l0 !== 8'd2) begin bad++; $display("FAIL bp_hold cyc=%0d got=%0d exp=2", i, d_l0); end
        end
        ready_i = 1'b1;
        #1;
        total++; if (d_ro !== 1'b1) begin bad++; $display("FAIL bp_ready_release got=%b exp=1", d_ro); end
        @(posedge clk);
        #1;
        total++; if (d_l0 !== 8'd4) begin bad++; $display("FAIL bp_drain1 got=%0d exp=4", d_l0); end
        a_i = 8'h03; b_i = 8'h03;
        @(posedge clk);
        #1;
        total++; if (d_l0 !== 8'd6) begin bad++; $display("FAIL bp_drain2 got=%0d exp=6", d_l0); end
        total++; if (d_vo !== 1'b1) begin bad++; $display("FAIL bp_drain2_valid got=%b exp=1", d_vo); end
        idle();
        total++; if (d_vo !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", d_vo); end
    endtask

    task automatic test_clr();
        beat(C_ACC, 4'd7, 4'd7, 4'd7, 4'd7);
        beat(C_ACC, 4'd7, 4'd7, 4'd7, 4'd7);
        beat(C_CLR, 4'd0, 4'd0, 4'd0, 4'd0);
        total++; if (d_vo !== 1'b0) begin bad++; $display("FAIL clr_no_out got=%b exp=0", d_vo); end
        beat(C_ACC, 4'd1, 4'd1, 4'd1, 4'd1);
        beat(C_RSV, 4'd9, 4'd9, 4'd9, 4'd9);
        total++; if (d_vo !== 1'b0) begin bad++; $display("FAIL rsv_no_out got=%b exp=0", d_vo); end
        beat(C_ADD, 4'd2, 4'd3, 4'd0, 4'd0);
        total++; if (d_vo !== 1'b1) begin bad++; $display("FAIL clr_add_valid got=%b exp=1", d_vo); end
        total++; if (d_l0 !== 8'd5) begin bad++; $display("FAIL clr_add_lane0 got=%0d exp=5", d_l0); end
        beat(C_ACC, 4'd1, 4'd1, 4'd1, 4'd1);
        total++; if (d_vo !== 1'b0) begin bad++; $display("FAIL clr_mid_valid got=%b exp=0", d_vo); end
        beat(C_ACC, 4'd1, 4'd1, 4'd1, 4'd1);
        total++; if (d_vo !== 1'b0) begin bad++; $display("FAIL clr_mid2_valid got=%b exp=0", d_vo); end
        beat(C_ACC, 4'd1, 4'd1, 4'd1, 4'd1);
        total++; if (d_vo !== 1'b1) begin bad++; $display("FAIL clr_dump_valid got=%b exp=1", d_vo); end
        total++; if (d_l0 !== 8'd8) begin bad++; $display("FAIL clr_dump_lane0 got=%0d exp=8", d_l0); end
        total++; if (d_l1 !== 8'd8) begin bad++; $display("FAIL clr_dump_lane1 got=%0d exp=8", d_l1); end
        total++; if (d_ovf !== 2'b00) begin bad++; $display("FAIL clr_dump_ovf got=%b exp=00", d_ovf); end
    endtask

    task automatic test_reset_stall();
        idle();
        beat(C_ACC, 4'd9, 4'd9, 4'd9, 4'd9);
        beat(C_ACC, 4'd9, 4'd9, 4'd9, 4'd9);
        ready_i = 1'b0;
        beat(C_ADD, 4'd1, 4'd2, 4'd0, 4'd0);
        idle();
        total++; if (d_l0 !== 8'd3 || d_vo !== 1'b1) begin bad++; $display("FAIL rst_stall_pre got=%0d/%b exp=3/1", d_l0, d_vo); end
        #2 rstb = 1'b0;
        #1;
        total++; if (d_vo !== 1'b0) begin bad++; $display("FAIL rst_stall_valid got=%b exp=0", d_vo); end
        total++; if (d_c !== 16'h0) begin bad++; $display("FAIL rst_stall_c got=%h exp=0000", d_c); end
        total++; if (d_ovf !== 2'b00) begin bad++; $display("FAIL rst_stall_ovf got=%b exp=00", d_ovf); end
        total++; if (d_ro !== 1'b1) begin bad++; $display("FAIL rst_stall_ready got=%b exp=1", d_ro); end
        #1 rstb = 1'b1;
        ready_i = 1'b1;
        beat(C_ACC, 4'd2, 4'd1, 4'd1, 4'd1);
        beat(C_ACC, 4'd2, 4'd1, 4'd1, 4'd1);
        total++; if (d_vo !== 1'b0) begin bad++; $display("FAIL rst_window_restart got=%b exp=0", d_vo); end
        beat(C_ACC, 4'd2, 4'd1, 4'd1, 4'd1);
        beat(C_ACC, 4'd2, 4'd1, 4'd1, 4'd1);
        total++; if (d_vo !== 1'b1) begin bad++; $display("FAIL rst_dump_valid got=%b exp=1", d_vo); end
        total++; if (d_l0 !== 8'd12) begin bad++; $display("FAIL rst_dump_lane0 got=%0d exp=12", d_l0); end
        total++; if (d_l1 !== 8'd8) begin bad++; $display("FAIL rst_dump_lane1 got=%0d exp=8", d_l1); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_acc_window();
        test_saturation();
        test_backpressure();
        test_clr();
        test_reset_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
